// File: rtl/rom_fetch_pkg.sv
// Shared definitions for the ROM byte-fetch block: FSM state encoding,
// default byte/word widths and the little-endian byte-select helper.
package rom_fetch_pkg;

    localparam int ROM_BYTE_W = 8;
    localparam int ROM_WORD_W = 2 * ROM_BYTE_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        ACK,
        PFETCH,
        PCAPT
    } state_t;

    // Little-endian: sel=0 picks the low byte, sel=1 the high byte.
    function automatic logic [ROM_BYTE_W-1:0] select_byte(
        input logic [ROM_WORD_W-1:0] word,
        input logic                  sel
    );
        return sel ? word[ROM_WORD_W-1:ROM_BYTE_W] : word[ROM_BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/rom_line_buf.sv
// One-word line buffer: valid/tag/data storage, hit compare against a
// lookup word address and the byte mux for the requested half.
module rom_line_buf
    import rom_fetch_pkg::*;
#(
    parameter int WORD_ADDR_W = 14,
    parameter int WORD_W      = ROM_WORD_W,
    parameter int BYTE_W      = ROM_BYTE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic [WORD_ADDR_W-1:0] load_tag,
    input  logic [WORD_W-1:0]      load_data,
    input  logic [WORD_ADDR_W-1:0] look_tag,
    input  logic                   sel,
    output logic                   hit,
    output logic [BYTE_W-1:0]      rdata
);

    logic                   valid;
    logic [WORD_ADDR_W-1:0] tag;
    logic [WORD_W-1:0]      data;

    // Capture a new word on load; clear wins over load for the valid bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (load) begin
                tag  <= load_tag;
                data <= load_data;
            end
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
        end
    end

    // Tag compare and byte selection for the current lookup address.
    always_comb begin
        hit   = valid && (tag == look_tag);
        rdata = select_byte(data, sel);
    end

endmodule

// File: rtl/rom_byte_fetch.sv
// CPU byte-read front end for the 16-bit synchronous program ROM.
// Serves byte requests from a one-word line buffer, fetching from ROM on
// a miss. Optional next-word prefetch buffer: ROM_BYTE_FETCH_PREFETCH_EN.
module rom_byte_fetch
    import rom_fetch_pkg::*;
#(
    parameter int WORD_ADDR_W = 14,
    parameter int WORD_W      = ROM_WORD_W,
    parameter int BYTE_W      = ROM_BYTE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic [WORD_ADDR_W:0]   cpu_addr,
    output logic [BYTE_W-1:0]      cpu_rdata,
    output logic                   cpu_ack,
    input  logic                   flush,
    output logic                   rom_enable,
    output logic [WORD_ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0]      rom_data
);

    state_t                 state;
    logic [WORD_ADDR_W-1:0] word_addr;
    logic                   byte_sel;
    logic                   hit_cur;
    logic [BYTE_W-1:0]      rdata_cur;

    // Split the CPU byte address into word address and byte select.
    always_comb begin
        word_addr = cpu_addr[WORD_ADDR_W:1];
        byte_sel  = cpu_addr[0];
    end

`ifdef ROM_BYTE_FETCH_PREFETCH_EN
    // Two physical buffers; cur names the one acting as the line buffer.
    // Promotion just flips cur instead of copying the word across.
    logic              cur;
    logic              pf_arm;
    logic              load0, load1;
    logic              hit0, hit1;
    logic              hit_alt;
    logic [BYTE_W-1:0] rdata0, rdata1, rdata_alt;

    // Demand captures go to the current buffer, prefetches to the other.
    always_comb begin
        load0     = ((state == CAPT) && !cur) || ((state == PCAPT) && cur);
        load1     = ((state == CAPT) && cur)  || ((state == PCAPT) && !cur);
        hit_cur   = (cur ? hit1 : hit0) && !flush;
        rdata_cur = cur ? rdata1 : rdata0;
        hit_alt   = (cur ? hit0 : hit1) && !flush;
        rdata_alt = cur ? rdata0 : rdata1;
    end

    rom_line_buf #(
        .WORD_ADDR_W(WORD_ADDR_W),
        .WORD_W     (WORD_W),
        .BYTE_W     (BYTE_W)
    ) u_buf0 (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .load     (load0),
        .load_tag (rom_addr),
        .load_data(rom_data),
        .look_tag (word_addr),
        .sel      (byte_sel),
        .hit      (hit0),
        .rdata    (rdata0)
    );

    rom_line_buf #(
        .WORD_ADDR_W(WORD_ADDR_W),
        .WORD_W     (WORD_W),
        .BYTE_W     (BYTE_W)
    ) u_buf1 (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .load     (load1),
        .load_tag (rom_addr),
        .load_data(rom_data),
        .look_tag (word_addr),
        .sel      (byte_sel),
        .hit      (hit1),
        .rdata    (rdata1)
    );
`else
    logic line_load;
    logic line_hit;

    // Line buffer fills from the ROM output while in CAPT.
    always_comb begin
        line_load = (state == CAPT);
        hit_cur   = line_hit && !flush;
    end

    rom_line_buf #(
        .WORD_ADDR_W(WORD_ADDR_W),
        .WORD_W     (WORD_W),
        .BYTE_W     (BYTE_W)
    ) u_line (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .load     (line_load),
        .load_tag (rom_addr),
        .load_data(rom_data),
        .look_tag (word_addr),
        .sel      (byte_sel),
        .hit      (line_hit),
        .rdata    (rdata_cur)
    );
`endif

    // Request FSM with registered CPU and ROM-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            rom_enable <= 1'b0;
            rom_addr   <= '0;
`ifdef ROM_BYTE_FETCH_PREFETCH_EN
            cur        <= 1'b0;
            pf_arm     <= 1'b0;
`endif
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
`ifdef ROM_BYTE_FETCH_PREFETCH_EN
                    pf_arm <= 1'b0;
`endif
                    if (cpu_req) begin
                        if (hit_cur) begin
                            cpu_rdata <= rdata_cur;
                            cpu_ack   <= 1'b1;
                            state     <= ACK;
`ifdef ROM_BYTE_FETCH_PREFETCH_EN
                        end else if (hit_alt) begin
                            cpu_rdata <= rdata_alt;
                            cpu_ack   <= 1'b1;
                            cur       <= ~cur;
                            state     <= ACK;
`endif
                        end else begin
                            rom_addr   <= word_addr;
                            rom_enable <= 1'b1;
                            state      <= FETCH;
                        end
`ifdef ROM_BYTE_FETCH_PREFETCH_EN
                    end else if (pf_arm) begin
                        // rom_addr still holds the word just captured.
                        rom_addr   <= rom_addr + WORD_ADDR_W'(1);
                        rom_enable <= 1'b1;
                        state      <= PFETCH;
`endif
                    end
                end
                FETCH: begin
                    state <= CAPT;
                end
                CAPT: begin
                    cpu_rdata  <= select_byte(rom_data, byte_sel);
                    cpu_ack    <= cpu_req;
                    rom_enable <= 1'b0;
                    state      <= ACK;
`ifdef ROM_BYTE_FETCH_PREFETCH_EN
                    pf_arm     <= 1'b1;
`endif
                end
                ACK: begin
                    state <= IDLE;
                end
                PFETCH: begin
                    state <= PCAPT;
                end
                PCAPT: begin
                    rom_enable <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    rom_enable <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_byte_fetch.sv
// Scoreboard bench for rom_byte_fetch: the driver queues the expected byte,
// latency and ROM-enable cycle count per request; a monitor pops and
// compares on every cpu_ack.
`timescale 1ns/1ps
module tb_rom_byte_fetch;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req;
    logic [AW:0]   cpu_addr;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic          flush;
    logic          rom_enable;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;

    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] rom_q;

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         en;
        int         start;
        int         en_base;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   en_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM model; output gated by the current enable.
    always @(posedge clk) if (rom_enable) rom_q <= mem[rom_addr];
    assign rom_data = rom_enable ? rom_q : 16'h0000;

    rom_byte_fetch #(
        .WORD_ADDR_W(AW),
        .WORD_W     (16),
        .BYTE_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .flush     (flush),
        .rom_enable(rom_enable),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rom_enable) en_total++;
            if (cpu_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack with rdata 0x%0h, expected no ack", cpu_rdata);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_data"},   int'(cpu_rdata),     int'(e.data));
                    check({e.name, "_lat"},    cyc - e.start,       e.lat);
                    check({e.name, "_rom_en"}, en_total - e.en_base, e.en);
                end
            end
        end
    endtask

    // flush_at: edge count after issue at which flush is raised for one
    // cycle (0 = together with the request, -1 = never).
    task automatic do_read(input logic [AW:0] addr, input logic [7:0] data,
                           input int lat, input int en, input int flush_at,
                           input string name);
        exp_t e;
        bit   got;
        int   n;
        e.data    = data;
        e.lat     = lat;
        e.en      = en;
        e.start   = cyc;
        e.en_base = en_total;
        e.name    = name;
        sb.push_back(e);
        cpu_addr = addr;
        cpu_req  = 1'b1;
        flush    = (flush_at == 0);
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            flush = (flush_at > 0 && n == flush_at);
            got   = cpu_ack;
        end
        if (got) begin
            @(posedge clk); #1;
        end else begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no cpu_ack after %0d cycles, expected ack", name, n);
            if (sb.size() > 0) e = sb.pop_back();
        end
        cpu_req = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_ack"},    int'(cpu_ack),    0);
        check({tag, "_cpu_rdata"},  int'(cpu_rdata),  0);
        check({tag, "_rom_enable"}, int'(rom_enable), 0);
        check({tag, "_rom_addr"},   int'(rom_addr),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        mem[0]       = 16'h5341;
        mem[1]       = 16'h7A12;
        mem[2]       = 16'h9C64;
        mem[3]       = 16'h2C3B;
        mem[14'h0B0] = 16'hFF00;
        mem[14'h3FFF] = 16'hE7D5;

        reset    = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        flush    = 1'b0;
        fork
            monitor();
        join_none

        idle(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(1);

`ifndef ROM_BYTE_FETCH_PREFETCH_EN
        do_read(15'h0000, 8'h41, 3, 2, -1, "rd0000_miss");
        do_read(15'h0001, 8'h53, 1, 0, -1, "rd0001_hit");
        do_read(15'h0006, 8'h3B, 3, 2, -1, "rd0006_miss");
        do_read(15'h0007, 8'h2C, 1, 0, -1, "rd0007_hit");
        check("rom_addr_word3", int'(rom_addr), 3);

        do_read(15'h0000, 8'h41, 3, 2, -1, "refill0000");
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        do_read(15'h0001, 8'h53, 3, 2, -1, "after_flush");

        do_read(15'h0000, 8'h41, 3, 2, 0, "flush_with_hit");
        do_read(15'h0001, 8'h53, 1, 0, -1, "hit_after_refill");

        do_read(15'h0004, 8'h64, 3, 2, 2, "flush_in_capt");
        do_read(15'h0005, 8'h9C, 3, 2, -1, "miss_after_capt_flush");

        cpu_addr = 15'h0160;
        cpu_req  = 1'b1;
        idle(1);
        check("fetch_started_en", int'(rom_enable), 1);
        check("fetch_started_addr", int'(rom_addr), 'h0B0);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_in_fetch");
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        do_read(15'h0160, 8'h00, 3, 2, -1, "rd0160_after_reset");
        do_read(15'h0161, 8'hFF, 1, 0, -1, "rd0161_hit");

        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        do_read(15'h0161, 8'hFF, 3, 2, -1, "rd0161_after_reset");

        do_read(15'h7FFF, 8'hE7, 3, 2, -1, "rd7fff_miss");
        check("rom_addr_top", int'(rom_addr), 'h3FFF);
        do_read(15'h7FFE, 8'hD5, 1, 0, -1, "rd7ffe_hit");
        idle(3);
        check("rdata_hold", int'(cpu_rdata), 'hD5);
        check("ack_idle", int'(cpu_ack), 0);
`else
        do_read(15'h7FFF, 8'hE7, 3, 2, -1, "pf_rd7fff_miss");
        idle(6);
        check("pf_wrap_addr", int'(rom_addr), 0);
        check("pf_enable_off", int'(rom_enable), 0);
        do_read(15'h0000, 8'h41, 1, 0, -1, "pf_rd0000_promote");
        check("pf_rom_addr_kept", int'(rom_addr), 0);
        do_read(15'h0001, 8'h53, 1, 0, -1, "pf_rd0001_hit");
        do_read(15'h7FFE, 8'hD5, 1, 0, -1, "pf_rd7ffe_alt_hit");
`endif

        idle(3);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_byte_fetch.md
Name: rom_byte_fetch

Overview:
- Downstream consumer of the 16-bit synchronous program ROM.
- Turns CPU byte-read requests into ROM word reads and returns one byte per request.
- Holds the last fetched word in a one-word line buffer, so sequential instruction fetches hit without a ROM access.
- Sits between the CPU instruction/data read port and the ROM.

Parameters:
- WORD_ADDR_W, 14, ROM word-address width; CPU byte address is WORD_ADDR_W+1 bits.
- WORD_W, 16, ROM word width; fixed at 2*BYTE_W.
- BYTE_W, 8, CPU data width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  read request; held high with cpu_addr stable until cpu_ack
- cpu_addr  in  WORD_ADDR_W+1  byte address; bit 0 selects the byte, upper bits are the word address
- cpu_rdata  out  BYTE_W  read byte; valid only while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- flush  in  1  invalidates the line buffer (ROM image changed)
- rom_enable  out  1  ROM enable; ROM output reads 0 when low
- rom_addr  out  WORD_ADDR_W  ROM word address, registered
- rom_data  in  WORD_W  ROM output; valid one cycle after rom_addr/rom_enable are presented

Behaviour:
- Reset values:
  - cpu_ack=0, cpu_rdata=0, rom_enable=0, rom_addr=0
  - line_valid=0, line_tag=0, line_data=0
  - state=IDLE
- Reset asserted in any state aborts any fetch immediately; the line buffer comes out invalid.
- Byte order is little-endian:
  - addr[0]=0 returns word[7:0]
  - addr[0]=1 returns word[15:8]
- Hit condition: line_valid && line_tag==cpu_addr[WORD_ADDR_W:1] && !flush.
- States:
  - IDLE:
    - cpu_req && hit: register the selected byte into cpu_rdata, go to ACK.
    - cpu_req && miss: register rom_addr=word address, set rom_enable=1, go to FETCH.
  - FETCH:
    - rom_enable stays 1; the ROM latches the address this cycle.
    - Go to CAPT.
  - CAPT:
    - rom_enable stays 1 (the ROM output is gated by enable).
    - Load line_data=rom_data, line_tag=rom_addr, line_valid=1.
    - Register the selected byte into cpu_rdata; go to ACK.
  - ACK:
    - cpu_ack=1 for exactly one cycle, rom_enable=0, return to IDLE.
    - If cpu_req is low here, cpu_ack is suppressed; the buffer stays filled.
- Latency, counted from the cycle cpu_req is first sampled high in IDLE:
  - hit: cpu_ack after 1 cycle
  - miss: cpu_ack after 3 cycles
  - back-to-back requests: IDLE is revisited for one cycle between requests.
- Flush handling:
  - flush in any state clears line_valid on the next edge.
  - flush in CAPT: the capture still completes and the byte is returned, but line_valid ends at 0 (flush wins).
  - flush together with a would-be hit in IDLE: handled as a miss.
- Address wrap: word address arithmetic is modulo 2^WORD_ADDR_W.
- rom_enable is never asserted outside FETCH/CAPT (and the PREFETCH states when compiled in).
- cpu_rdata holds its last value when cpu_ack=0.

Optional Feature:
- Macro: ROM_BYTE_FETCH_PREFETCH_EN.
- When defined:
  - Adds a second buffer (next_valid/next_tag/next_data).
  - After every CAPT→ACK→IDLE with no pending cpu_req, runs PFETCH/PCAPT on word line_tag+1 (wrapping at 2^WORD_ADDR_W to 0).
  - A cpu_req arriving during PFETCH/PCAPT waits until PCAPT completes.
  - A request that hits the next buffer promotes it to the line buffer and completes in 1 cycle.
  - flush clears both buffers.
- When undefined: single buffer only; the states above are the complete FSM.

Decomposition:
- Shared package rom_fetch_pkg:
  - state enum (IDLE, FETCH, CAPT, ACK, PFETCH, PCAPT)
  - localparams for BYTE_W/WORD_W
  - byte-select helper function
- One natural sub-module: rom_line_buf, holding valid/tag/data, the hit compare and the byte mux. It is instantiated twice when prefetch is enabled.

Test Plan:
- After reset, read byte 0x0000 with ROM word 0=0x5341 → rom_enable high for 2 cycles; cpu_ack 3 cycles after request; cpu_rdata=0x41.
- Immediately read 0x0001 → no rom_enable; cpu_ack after 1 cycle; cpu_rdata=0x53.
- Read 0x0006 (word 3=0x2C3B) then 0x0007 → 0x3B (miss, 3 cycles) then 0x2C (hit, 1 cycle); rom_addr=0x0003.
- Fill word 0, assert flush for one cycle, read 0x0001 → miss path taken; cpu_rdata=0x53.
- Assert reset during FETCH for word 0x00B0 → outputs return to reset values at once; the next read of 0x0160 (word 0xB0=0xFF00) misses and returns 0x00.
- With ROM_BYTE_FETCH_PREFETCH_EN defined, read 0x7FFF then idle → prefetch of rom_addr=0x0000; the next read of 0x0000 acks in 1 cycle with 0x41 and no further ROM access.
